// File: rtl/link_mem_responder_pkg.sv
// ============================================================================
// Module   : link_pkg
// Purpose  : Shared types and constants for the byte-serial CPU link responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package link_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_STORE = 2'b01,
    OP_LOAD  = 2'b10,
    OP_JUMP  = 2'b11
  } link_op_t;

  typedef enum logic [3:0] {
    ST_PREFETCH  = 4'd0,
    ST_LOAD_INST = 4'd1,
    ST_WAIT_SOF  = 4'd2,
    ST_SEND_INST = 4'd3,
    ST_WAIT_EXEC = 4'd4,
    ST_RECV_ADDR = 4'd5,
    ST_DISPATCH  = 4'd6,
    ST_LOAD_DATA = 4'd7,
    ST_SEND_DATA = 4'd8
  } link_state_t;

  localparam logic [7:0]  LINK_STALL_MARK = 8'hFF;
  localparam int unsigned LINK_BEATS      = 4;
  localparam logic [1:0]  LINK_LAST_BEAT  = 2'(LINK_BEATS - 1);

endpackage

`default_nettype wire

// File: rtl/link_mem_responder_if.sv
// ============================================================================
// Module   : link_mem_responder_if
// Purpose  : CPU-link byte bus plus word-wide SRAM port seen by the responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface link_mem_responder_if #(
  parameter int MEM_AW = 6
);
  logic              link_sof;
  logic              link_exec;
  logic [1:0]        link_op;
  logic [7:0]        link_addr;
  logic [7:0]        link_wdata;
  logic [7:0]        link_rdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  // Responder side
  modport slave (
    input  link_sof, link_exec, link_op, link_addr, link_wdata, mem_rdata,
    output link_rdata, mem_addr, mem_wdata, mem_we, mem_re
  );

  // CPU / SRAM environment side
  modport master (
    output link_sof, link_exec, link_op, link_addr, link_wdata, mem_rdata,
    input  link_rdata, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

`default_nettype wire

// File: rtl/link_word_assembler.sv
// ============================================================================
// Module   : link_word_assembler
// Purpose  : Collects four link bytes, little-endian, into a 32-bit word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module link_word_assembler
  import link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // Shifting right places the first byte received in bits [7:0] after four beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (clr) begin
      r_cnt  <= '0;
    end else if (en) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= {din, r_word[31:8]};
    end
  end

  assign word = r_word;
  assign last = (r_cnt == LINK_LAST_BEAT);

endmodule

`default_nettype wire

// File: rtl/link_mem_responder.sv
// ============================================================================
// Module   : link_mem_responder
// Purpose  : Memory-side responder for the byte-serial CPU link: PC, fetch,
//            load/store/jump over a word-wide synchronous SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module link_mem_responder
  import link_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  link_mem_responder_if.slave  lnk,
  output logic [31:0]          pc_dbg,
  output logic                 frame_err
);

  link_state_t       r_state, w_state_nxt;
  link_op_t          r_op;
  logic [31:0]       r_pc, w_pc_nxt;
  logic [31:0]       r_inst, r_data;
  logic [1:0]        r_beat;
  logic              r_sof_pend;
  logic              r_frame_err;

  logic [7:0]        w_rdata;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [31:0]       w_mem_wdata;
  logic              w_mem_we, w_mem_re;
  logic              w_asm_en, w_asm_clr;
  logic [31:0]       w_addr_word, w_data_word;
  logic              w_addr_last, w_data_last;
  logic              w_abort, w_beat_last, w_recv_done;

  // SOF is only legal while idle; anywhere else it restarts the frame.
  assign w_abort = lnk.link_sof && (r_state != ST_PREFETCH) &&
                   (r_state != ST_LOAD_INST) && (r_state != ST_WAIT_SOF);
  assign w_beat_last = (r_beat == LINK_LAST_BEAT);
  assign w_recv_done = w_addr_last & w_data_last;
  assign w_asm_clr   = (r_state != ST_RECV_ADDR) | w_abort;

  link_word_assembler u_addr_asm (
    .clk(clk), .rst(rst), .clr(w_asm_clr), .en(w_asm_en),
    .din(lnk.link_addr), .word(w_addr_word), .last(w_addr_last)
  );

  link_word_assembler u_data_asm (
    .clk(clk), .rst(rst), .clr(w_asm_clr), .en(w_asm_en),
    .din(lnk.link_wdata), .word(w_data_word), .last(w_data_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rdata     = '0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_asm_en    = 1'b0;
    case (r_state)
      ST_PREFETCH: begin
        w_mem_re    = 1'b1;
        w_mem_addr  = r_pc[MEM_AW+1:2];
        w_state_nxt = ST_LOAD_INST;
      end
      ST_LOAD_INST: w_state_nxt = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (lnk.link_sof || r_sof_pend) w_state_nxt = ST_SEND_INST;
      end
      ST_SEND_INST: begin
        w_rdata = r_inst[{r_beat, 3'b000} +: 8];
        if (w_beat_last) w_state_nxt = ST_WAIT_EXEC;
      end
      ST_WAIT_EXEC: begin
        if (lnk.link_exec) begin
          if (link_op_t'(lnk.link_op) == OP_NONE) begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = ST_PREFETCH;
          end else begin
            w_state_nxt = ST_RECV_ADDR;
          end
        end
      end
      ST_RECV_ADDR: begin
        w_asm_en = 1'b1;
        if (w_recv_done) w_state_nxt = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        w_mem_addr  = w_addr_word[MEM_AW+1:2];
        w_state_nxt = ST_PREFETCH;
        case (r_op)
          OP_STORE: begin
            w_mem_we    = 1'b1;
            w_mem_wdata = w_data_word;
            w_pc_nxt    = r_pc + 32'd4;
          end
          OP_JUMP:  w_pc_nxt = w_addr_word;
          OP_LOAD: begin
            w_mem_re    = 1'b1;
            w_state_nxt = ST_LOAD_DATA;
          end
          default: w_mem_addr = '0;
        endcase
      end
      ST_LOAD_DATA: w_state_nxt = ST_SEND_DATA;
      ST_SEND_DATA: begin
        w_rdata = r_data[{r_beat, 3'b000} +: 8];
        if (w_beat_last) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = ST_PREFETCH;
        end
      end
      default: w_state_nxt = ST_PREFETCH;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_SEND_INST;
      w_pc_nxt    = r_pc;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_asm_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_PREFETCH;
      r_op        <= OP_NONE;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_data      <= '0;
      r_beat      <= '0;
      r_sof_pend  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_frame_err <= w_abort;
      r_beat      <= (w_abort || (w_state_nxt != r_state)) ? 2'd0 : r_beat + 2'd1;
      if (r_state == ST_LOAD_INST) r_inst <= lnk.mem_rdata;
      if (r_state == ST_LOAD_DATA) r_data <= lnk.mem_rdata;
      if (r_state == ST_WAIT_EXEC && lnk.link_exec && !w_abort)
        r_op <= link_op_t'(lnk.link_op);
      // Early SOF from a CPU that finished PREPARE before the fetch completed.
      if ((r_state == ST_PREFETCH || r_state == ST_LOAD_INST) && lnk.link_sof)
        r_sof_pend <= 1'b1;
      else if (r_state == ST_WAIT_SOF)
        r_sof_pend <= 1'b0;
    end
  end

  // Outputs are combinational per state, so hold them at rest while reset is low.
  assign lnk.link_rdata = rst ? w_rdata     : 8'h00;
  assign lnk.mem_addr   = rst ? w_mem_addr  : '0;
  assign lnk.mem_wdata  = rst ? w_mem_wdata : 32'h0;
  assign lnk.mem_we     = rst & w_mem_we;
  assign lnk.mem_re     = rst & w_mem_re;
  assign pc_dbg         = r_pc;
  assign frame_err      = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_link_mem_responder.sv
// ============================================================================
// Module   : tb_link_mem_responder
// Purpose  : Directed plus randomized frames against a PC/memory reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_link_mem_responder;
  import link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  link_mem_responder_if #(.MEM_AW(6)) bus ();
  logic [31:0] pc_dbg;
  logic        frame_err;

  link_mem_responder #(.RESET_PC(32'h0), .MEM_AW(6)) dut (
    .clk(clk), .rst(rst), .lnk(bus), .pc_dbg(pc_dbg), .frame_err(frame_err)
  );

  logic [31:0] sram    [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] ref_pc;
  int tests = 0, fails = 0;
  int we_cnt = 0, err_cnt = 0, both_cnt = 0;
  int exp_we = 0, exp_err = 0;

  // Synchronous SRAM environment plus event monitors
  always @(posedge clk) begin
    if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr];
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (bus.mem_we && bus.mem_re) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    bus.link_sof  = 1'b0;
    bus.link_exec = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rdata", bus.link_rdata, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_mwdata", bus.mem_wdata, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_pc", pc_dbg, 32'h0);
    chk("rst_ferr", frame_err, 0);
  endtask

  // Leaves the DUT one cycle before WAIT_SOF
  task automatic rst_release();
    rst = 1'b0;
    ref_pc = 32'h0;
    repeat (2) cyc();
    #1 chk_reset_outputs();
    cyc();
    rst = 1'b1;
    #1 chk("pf_re", bus.mem_re, 1);
    chk("pf_addr", bus.mem_addr, 0);
    cyc();
    #1 chk("li_re", bus.mem_re, 0);
  endtask

  // Fetch cycle pair after a frame; optionally issue SOF early
  task automatic post(input bit early);
    cyc();
    if (early) bus.link_sof = 1'b1;
    #1 chk("pf_re", bus.mem_re, 1);
    chk("pf_addr", bus.mem_addr, {26'd0, ref_pc[7:2]});
    chk("pc", pc_dbg, ref_pc);
    cyc();
    #1 chk("li_re", bus.mem_re, 0);
    chk("we_count", we_cnt, exp_we);
    chk("ferr_count", err_cnt, exp_err);
  endtask

  task automatic frame(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input bit pend, input bit abort, input bit mid_rst);
    logic [31:0] inst, exp;
    inst = ref_mem[ref_pc[7:2]];
    cyc();
    if (!pend) bus.link_sof = 1'b1;
    #1 chk("wsof_rd", bus.link_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1 chk("inst_byte", bus.link_rdata, {24'd0, inst[8*k +: 8]});
    end
    cyc();
    bus.link_exec = 1'b1;
    bus.link_op   = op;
    #1 chk("wexec_rd", bus.link_rdata, 0);
    if (op == 2'b00) begin
      ref_pc += 32'd4;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.link_addr  = addr[8*k +: 8];
      bus.link_wdata = wd[8*k +: 8];
      if (abort && k == 1) bus.link_sof = 1'b1;
      #1 chk("recv_we", bus.mem_we, 0);
      if (abort && k == 1) begin
        exp_err++;
        for (int j = 0; j < 4; j++) begin
          cyc();
          #1 chk("resend_byte", bus.link_rdata, {24'd0, inst[8*j +: 8]});
          chk("abort_pc", pc_dbg, ref_pc);
          chk("abort_ferr", frame_err, (j == 0) ? 1 : 0);
        end
        cyc();
        bus.link_exec = 1'b1;
        bus.link_op   = 2'b00;
        #1 chk("abort_we", bus.mem_we, 0);
        ref_pc += 32'd4;
        return;
      end
    end
    cyc();
    #1;
    case (op)
      2'b01: begin
        chk("st_we", bus.mem_we, 1);
        chk("st_re", bus.mem_re, 0);
        chk("st_addr", bus.mem_addr, {26'd0, addr[7:2]});
        chk("st_wdata", bus.mem_wdata, wd);
        ref_mem[addr[7:2]] = wd;
        exp_we++;
        ref_pc += 32'd4;
      end
      2'b11: begin
        chk("jmp_we", bus.mem_we, 0);
        ref_pc = addr;
      end
      default: begin
        chk("ld_re", bus.mem_re, 1);
        chk("ld_addr", bus.mem_addr, {26'd0, addr[7:2]});
        exp = ref_mem[addr[7:2]];
        cyc();
        bus.link_addr = LINK_STALL_MARK;
        #1 chk("stall_rd", bus.link_rdata, 0);
        for (int k = 0; k < 4; k++) begin
          cyc();
          if (mid_rst && k == 1) begin
            rst = 1'b0;
            #1 chk_reset_outputs();
            return;
          end
          #1 chk("ld_byte", bus.link_rdata, {24'd0, exp[8*k +: 8]});
        end
        ref_pc += 32'd4;
      end
    endcase
  endtask

  initial begin
    logic [31:0] a, d;
    bit          e;
    bus.link_sof = 1'b0; bus.link_exec = 1'b0; bus.link_op = 2'b00;
    bus.link_addr = 8'h00; bus.link_wdata = 8'h00;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      sram[i] = d;
      ref_mem[i] = d;
    end
    sram[0] = 32'h2002_0005; ref_mem[0] = 32'h2002_0005;
    sram[4] = 32'hCAFE_F00D; ref_mem[4] = 32'hCAFE_F00D;

    rst_release();
    frame(2'b00, 32'h0, 32'h0, 0, 0, 0);                 post(0);   // fetch 05,00,02,20; PC=4
    frame(2'b10, 32'h10, 32'h0, 0, 0, 0);                post(0);   // load CAFEF00D
    frame(2'b01, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);        post(0);   // store to word 4
    frame(2'b10, 32'h10, 32'h0, 0, 0, 0);                post(1);   // read back, early SOF next
    frame(2'b11, 32'h20, 32'h0, 1, 0, 0);                post(0);   // jump -> fetch word 8
    frame(2'b01, 32'h0000_0030, 32'h1234_5678, 0, 1, 0); post(0);   // aborted store
    frame(2'b01, 32'h0000_0104, 32'hA5A5_5A5A, 0, 0, 0); post(0);   // word index wraps to 1

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      d = $urandom;
      e = ($urandom_range(0, 3) == 0);
      frame(2'($urandom_range(0, 3)), a, d, 0, ($urandom_range(0, 7) == 0), 0);
      post(e);
      if (e) frame(2'b00, 32'h0, 32'h0, 1, 0, 0);
      else   frame(2'b00, 32'h0, 32'h0, 0, 0, 0);
      post(0);
    end

    frame(2'b10, 32'h0000_0014, 32'h0, 0, 0, 1);                    // reset mid SEND_DATA
    rst_release();
    frame(2'b00, 32'h0, 32'h0, 0, 0, 0);                 post(0);

    chk("we_re_excl", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
